// File: rtl/reservation_station_if.sv
// Dispatch, CDB snoop and issue signals between decode/rename, the reservation
// station and the execute stage. master = surrounding pipeline, slave = station.
interface reservation_station_if #(
  parameter int TAG_W = 4
);
  logic             flush;
  logic             disp_valid;
  logic             disp_ready;
  logic [2:0]       disp_unit;
  logic [9:0]       disp_op;
  logic [31:0]      disp_pc_plus4;
  logic [31:0]      disp_vj;
  logic [31:0]      disp_vk;
  logic [TAG_W-1:0] disp_qj;
  logic [TAG_W-1:0] disp_qk;
  logic             disp_qj_busy;
  logic             disp_qk_busy;
  logic [TAG_W-1:0] disp_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;
  logic             issue_valid;
  logic             issue_ready;
  logic [2:0]       issue_unit;
  logic [9:0]       issue_op;
  logic [31:0]      issue_pc_plus4;
  logic [31:0]      issue_vj;
  logic [31:0]      issue_vk;
  logic [TAG_W-1:0] issue_tag;

  modport master (
    output flush, disp_valid, disp_unit, disp_op, disp_pc_plus4, disp_vj, disp_vk,
           disp_qj, disp_qk, disp_qj_busy, disp_qk_busy, disp_tag,
           cdb_valid, cdb_tag, cdb_value, issue_ready,
    input  disp_ready, issue_valid, issue_unit, issue_op, issue_pc_plus4,
           issue_vj, issue_vk, issue_tag
  );

  modport slave (
    input  flush, disp_valid, disp_unit, disp_op, disp_pc_plus4, disp_vj, disp_vk,
           disp_qj, disp_qk, disp_qj_busy, disp_qk_busy, disp_tag,
           cdb_valid, cdb_tag, cdb_value, issue_ready,
    output disp_ready, issue_valid, issue_unit, issue_op, issue_pc_plus4,
           issue_vj, issue_vk, issue_tag
  );
endinterface

// File: rtl/reservation_station.sv
// Collapsing-queue reservation station: captures operands from the CDB and
// issues the oldest fully-ready entry to execute; flush empties it.
module reservation_station #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reservation_station_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [2:0]       unit;
    logic [9:0]       op;
    logic [31:0]      pc_plus4;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic             qj_busy;
    logic             qk_busy;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t        r_slot [DEPTH];
  logic [CW-1:0] r_count;

  entry_t        w_next [DEPTH];
  entry_t        w_disp_entry;
  entry_t        w_sel_entry;
  logic [IW-1:0] w_sel;
  logic          w_found;
  logic          w_issue_valid;
  logic          w_issue_fire;
  logic          w_disp_fire;
  logic [CW-1:0] w_wr_idx;

  // Same rule serves both registered-entry wakeup and the dispatch bypass.
  function automatic entry_t snoop(input entry_t e, input logic v,
                                   input logic [TAG_W-1:0] t, input logic [31:0] val);
    entry_t r;
    r = e;
    if (v && e.qj_busy && e.qj == t) begin
      r.vj      = val;
      r.qj_busy = 1'b0;
    end
    if (v && e.qk_busy && e.qk == t) begin
      r.vk      = val;
      r.qk_busy = 1'b0;
    end
    return r;
  endfunction

  // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i < int'(r_count) && !r_slot[i].qj_busy && !r_slot[i].qk_busy) begin
        w_found = 1'b1;
        w_sel   = IW'(i);
      end
    end
  end

  assign w_sel_entry    = r_slot[w_sel];
  assign w_issue_valid  = w_found && !bus.flush;
  assign w_issue_fire   = w_issue_valid && bus.issue_ready;
  assign w_disp_fire    = bus.disp_valid && bus.disp_ready && !bus.flush;
  assign w_wr_idx       = w_issue_fire ? r_count - CW'(1) : r_count;

  assign bus.disp_ready     = (r_count < CW'(DEPTH));
  assign bus.issue_valid    = w_issue_valid;
  assign bus.issue_unit     = w_issue_valid ? w_sel_entry.unit     : '0;
  assign bus.issue_op       = w_issue_valid ? w_sel_entry.op       : '0;
  assign bus.issue_pc_plus4 = w_issue_valid ? w_sel_entry.pc_plus4 : '0;
  assign bus.issue_vj       = w_issue_valid ? w_sel_entry.vj       : '0;
  assign bus.issue_vk       = w_issue_valid ? w_sel_entry.vk       : '0;
  assign bus.issue_tag      = w_issue_valid ? w_sel_entry.tag      : '0;

  assign w_disp_entry = snoop(entry_t'{unit: bus.disp_unit, op: bus.disp_op,
                                       pc_plus4: bus.disp_pc_plus4,
                                       vj: bus.disp_vj, vk: bus.disp_vk,
                                       qj: bus.disp_qj, qk: bus.disp_qk,
                                       qj_busy: bus.disp_qj_busy,
                                       qk_busy: bus.disp_qk_busy,
                                       tag: bus.disp_tag},
                              bus.cdb_valid, bus.cdb_tag, bus.cdb_value);

  // Collapse above the issued slot, then wake, then drop the new entry at the tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_next[i] = r_slot[i];
      if (w_issue_fire && i >= int'(w_sel) && i < DEPTH - 1)
        w_next[i] = r_slot[(i + 1) % DEPTH];
      w_next[i] = snoop(w_next[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
      if (w_disp_fire && i == int'(w_wr_idx))
        w_next[i] = w_disp_entry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= '0;
    else if (bus.flush)
      r_count <= '0;
    else
      r_count <= r_count + CW'(w_disp_fire) - CW'(w_issue_fire);
  end

  // NOTE: payload storage has no reset; occupancy is defined by r_count alone.
  always_ff @(posedge clk) begin
    r_slot <= w_next;
  end
endmodule

// File: tb/tb_reservation_station.sv
// Directed scenarios plus randomized traffic against a queue-based model of
// the reservation station.
module tb_reservation_station;
  localparam int DEPTH = 4;
  localparam logic [2:0] U_ALU = 3'd0, U_BRANCH = 3'd1, U_MUL = 3'd2, U_DIV = 3'd3;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  reservation_station_if #(.TAG_W(4)) bus ();

  reservation_station #(.DEPTH(DEPTH), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  unit;
    logic [9:0]  op;
    logic [31:0] pc;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [3:0]  qj;
    logic [3:0]  qk;
    bit          jb;
    bit          kb;
    logic [3:0]  tag;
  } rs_ent_t;

  rs_ent_t model_q[$];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.flush      = 1'b0;
    bus.disp_valid = 1'b0;
    bus.cdb_valid  = 1'b0;
    bus.cdb_tag    = 4'hF;
    bus.cdb_value  = 32'hDEAD_DEAD;
  endtask

  task automatic drive_disp(input logic [3:0] tag, input logic [31:0] vj, input logic [31:0] vk,
                            input bit jb, input logic [3:0] qj, input bit kb, input logic [3:0] qk);
    bus.disp_valid    = 1'b1;
    bus.disp_unit     = U_ALU;
    bus.disp_op       = 10'h033;
    bus.disp_pc_plus4 = 32'h1000 + 32'(tag);
    bus.disp_vj       = vj;
    bus.disp_vk       = vk;
    bus.disp_qj_busy  = jb;
    bus.disp_qj       = qj;
    bus.disp_qk_busy  = kb;
    bus.disp_qk       = qk;
    bus.disp_tag      = tag;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_value = val;
  endtask

  task automatic randomize_inputs();
    bus.flush         = 1'($urandom);
    bus.disp_valid    = 1'($urandom);
    bus.disp_unit     = 3'($urandom);
    bus.disp_op       = 10'($urandom);
    bus.disp_pc_plus4 = $urandom;
    bus.disp_vj       = $urandom;
    bus.disp_vk       = $urandom;
    bus.disp_qj       = 4'($urandom);
    bus.disp_qk       = 4'($urandom);
    bus.disp_qj_busy  = 1'($urandom);
    bus.disp_qk_busy  = 1'($urandom);
    bus.disp_tag      = 4'($urandom);
    bus.cdb_valid     = 1'($urandom);
    bus.cdb_tag       = 4'($urandom);
    bus.cdb_value     = $urandom;
    bus.issue_ready   = 1'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      randomize_inputs();
      tick();
      #1;
      if (bus.disp_ready !== 1'b1) begin n_err++; $display("FAIL reset_disp_ready: got %b expected 1", bus.disp_ready); end
      n_vec++;
      if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL reset_issue_valid: got %b expected 0", bus.issue_valid); end
      n_vec++;
      if (bus.issue_vj !== 32'd0) begin n_err++; $display("FAIL reset_issue_vj: got %h expected 0", bus.issue_vj); end
      n_vec++;
    end
    idle();
    bus.issue_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    drive_disp(4'd3, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0);
    #1;
    if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL first_no_comb_path: got %b expected 0", bus.issue_valid); end
    n_vec++;
    tick();
    idle();
    #1;
    if ({bus.issue_valid, bus.issue_vj, bus.issue_vk, bus.issue_tag, bus.issue_op, bus.issue_unit} !==
        {1'b1, 32'd5, 32'd7, 4'd3, 10'h033, U_ALU}) begin
      n_err++;
      $display("FAIL first_issue: got v=%b vj=%h vk=%h tag=%h op=%h expected v=1 vj=5 vk=7 tag=3 op=033",
               bus.issue_valid, bus.issue_vj, bus.issue_vk, bus.issue_tag, bus.issue_op);
    end
    n_vec++;
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    #1;
    if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL first_drained: got %b expected 0", bus.issue_valid); end
    n_vec++;
    // Asynchronous reset mid-operation, between clock edges.
    drive_disp(4'd9, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    idle();
    #1;
    if (bus.issue_valid !== 1'b1) begin n_err++; $display("FAIL async_pre: got %b expected 1", bus.issue_valid); end
    n_vec++;
    #2 rst_n = 1'b0;
    #1;
    if ({bus.issue_valid, bus.disp_ready, bus.issue_tag} !== {1'b0, 1'b1, 4'd0}) begin
      n_err++;
      $display("FAIL async_reset: got v=%b rdy=%b tag=%h expected v=0 rdy=1 tag=0", bus.issue_valid, bus.disp_ready, bus.issue_tag);
    end
    n_vec++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_wakeup();
    idle();
    bus.issue_ready = 1'b1;
    drive_disp(4'd1, 32'd0, 32'd2, 1'b1, 4'd9, 1'b0, 4'd0);
    tick();
    idle();
    #1;
    if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL wake_waiting: got %b expected 0", bus.issue_valid); end
    n_vec++;
    cdb(4'd9, 32'h1234);
    #1;
    if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL wake_no_same_cycle: got %b expected 0", bus.issue_valid); end
    n_vec++;
    tick();
    idle();
    #1;
    if ({bus.issue_valid, bus.issue_vj, bus.issue_vk, bus.issue_tag} !== {1'b1, 32'h1234, 32'd2, 4'd1}) begin
      n_err++;
      $display("FAIL wake_issue: got v=%b vj=%h vk=%h tag=%h expected v=1 vj=1234 vk=2 tag=1",
               bus.issue_valid, bus.issue_vj, bus.issue_vk, bus.issue_tag);
    end
    n_vec++;
    tick();
    drive_disp(4'd2, 32'd0, 32'd3, 1'b1, 4'd9, 1'b0, 4'd0);
    cdb(4'd9, 32'hBEEF);
    tick();
    idle();
    #1;
    if ({bus.issue_valid, bus.issue_vj, bus.issue_tag} !== {1'b1, 32'hBEEF, 4'd2}) begin
      n_err++;
      $display("FAIL bypass_issue: got v=%b vj=%h tag=%h expected v=1 vj=beef tag=2", bus.issue_valid, bus.issue_vj, bus.issue_tag);
    end
    n_vec++;
    tick();
    drive_disp(4'd4, 32'd0, 32'd0, 1'b1, 4'd6, 1'b1, 4'd6);
    tick();
    idle();
    cdb(4'd6, 32'h55);
    tick();
    idle();
    #1;
    if ({bus.issue_valid, bus.issue_vj, bus.issue_vk, bus.issue_tag} !== {1'b1, 32'h55, 32'h55, 4'd4}) begin
      n_err++;
      $display("FAIL dual_wake: got v=%b vj=%h vk=%h tag=%h expected v=1 vj=55 vk=55 tag=4",
               bus.issue_valid, bus.issue_vj, bus.issue_vk, bus.issue_tag);
    end
    n_vec++;
    tick();
  endtask

  task automatic test_oldest_first();
    idle();
    bus.issue_ready = 1'b0;
    drive_disp(4'd1, 32'd0, 32'd1, 1'b1, 4'd8, 1'b0, 4'd0);
    tick();
    drive_disp(4'd2, 32'd2, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    drive_disp(4'd3, 32'd3, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    idle();
    bus.issue_ready = 1'b1;
    for (int t = 2; t <= 3; t++) begin
      #1;
      if ({bus.issue_valid, bus.issue_tag} !== {1'b1, 4'(t)}) begin
        n_err++;
        $display("FAIL oldest_order: got v=%b tag=%h expected v=1 tag=%h", bus.issue_valid, bus.issue_tag, 4'(t));
      end
      n_vec++;
      tick();
    end
    #1;
    if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL oldest_blocked: got %b expected 0", bus.issue_valid); end
    n_vec++;
    cdb(4'd8, 32'h77);
    tick();
    idle();
    #1;
    if ({bus.issue_valid, bus.issue_tag, bus.issue_vj} !== {1'b1, 4'd1, 32'h77}) begin
      n_err++;
      $display("FAIL oldest_late: got v=%b tag=%h vj=%h expected v=1 tag=1 vj=77", bus.issue_valid, bus.issue_tag, bus.issue_vj);
    end
    n_vec++;
    tick();
    #1;
    if ({bus.issue_valid, bus.disp_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL oldest_empty: got v=%b rdy=%b expected v=0 rdy=1", bus.issue_valid, bus.disp_ready);
    end
    n_vec++;
  endtask

  task automatic test_full_backpressure();
    idle();
    bus.issue_ready = 1'b0;
    for (int t = 1; t <= DEPTH; t++) begin
      drive_disp(4'(t), 32'(t * 16), 32'(t), 1'b0, 4'd0, 1'b0, 4'd0);
      tick();
    end
    idle();
    for (int c = 0; c < 5; c++) begin
      #1;
      if ({bus.disp_ready, bus.issue_valid, bus.issue_tag, bus.issue_vj, bus.issue_pc_plus4} !==
          {1'b0, 1'b1, 4'd1, 32'h10, 32'h1001}) begin
        n_err++;
        $display("FAIL full_hold: got rdy=%b v=%b tag=%h vj=%h pc=%h expected rdy=0 v=1 tag=1 vj=10 pc=1001",
                 bus.disp_ready, bus.issue_valid, bus.issue_tag, bus.issue_vj, bus.issue_pc_plus4);
      end
      n_vec++;
      tick();
    end
    bus.issue_ready = 1'b1;
    drive_disp(4'd5, 32'h50, 32'd5, 1'b0, 4'd0, 1'b0, 4'd0);
    #1;
    if (bus.disp_ready !== 1'b0) begin n_err++; $display("FAIL full_refuse: got %b expected 0", bus.disp_ready); end
    n_vec++;
    tick();
    bus.issue_ready = 1'b0;
    #1;
    if ({bus.disp_ready, bus.issue_tag} !== {1'b1, 4'd2}) begin
      n_err++;
      $display("FAIL full_resume: got rdy=%b tag=%h expected rdy=1 tag=2", bus.disp_ready, bus.issue_tag);
    end
    n_vec++;
    tick();
    idle();
    #1;
    if (bus.disp_ready !== 1'b0) begin n_err++; $display("FAIL full_again: got %b expected 0", bus.disp_ready); end
    n_vec++;
    bus.issue_ready = 1'b1;
    for (int t = 2; t <= 5; t++) begin
      #1;
      if ({bus.issue_valid, bus.issue_tag} !== {1'b1, 4'(t)}) begin
        n_err++;
        $display("FAIL full_drain: got v=%b tag=%h expected v=1 tag=%h", bus.issue_valid, bus.issue_tag, 4'(t));
      end
      n_vec++;
      tick();
    end
    #1;
    if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL full_drained: got %b expected 0", bus.issue_valid); end
    n_vec++;
  endtask

  task automatic test_flush();
    idle();
    bus.issue_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      drive_disp(4'(t), 32'(t), 32'(t), 1'b0, 4'd0, 1'b0, 4'd0);
      tick();
    end
    drive_disp(4'd4, 32'd4, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0);
    bus.flush       = 1'b1;
    bus.issue_ready = 1'b1;
    #1;
    if ({bus.issue_valid, bus.issue_tag} !== {1'b0, 4'd0}) begin
      n_err++;
      $display("FAIL flush_cycle: got v=%b tag=%h expected v=0 tag=0", bus.issue_valid, bus.issue_tag);
    end
    n_vec++;
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      if ({bus.issue_valid, bus.disp_ready} !== 2'b01) begin
        n_err++;
        $display("FAIL flush_empty: got v=%b rdy=%b expected v=0 rdy=1", bus.issue_valid, bus.disp_ready);
      end
      n_vec++;
      tick();
    end
    bus.issue_ready = 1'b0;
    for (int t = 6; t <= 9; t++) begin
      drive_disp(4'(t), 32'(t), 32'(t), 1'b0, 4'd0, 1'b0, 4'd0);
      #1;
      if (bus.disp_ready !== 1'b1) begin n_err++; $display("FAIL flush_count: got %b expected 1", bus.disp_ready); end
      n_vec++;
      tick();
    end
    idle();
    #1;
    if ({bus.disp_ready, bus.issue_tag} !== {1'b0, 4'd6}) begin
      n_err++;
      $display("FAIL flush_refill: got rdy=%b tag=%h expected rdy=0 tag=6", bus.disp_ready, bus.issue_tag);
    end
    n_vec++;
    bus.flush = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_cdb_nomatch();
    idle();
    bus.issue_ready = 1'b1;
    drive_disp(4'd1, 32'hAAAA, 32'hBBBB, 1'b1, 4'd5, 1'b1, 4'd6);
    tick();
    idle();
    cdb(4'd7, 32'hDEAD);
    tick();
    idle();
    bus.cdb_tag   = 4'd5;
    bus.cdb_value = 32'hDEAD;
    tick();
    #1;
    if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL nomatch_idle: got %b expected 0", bus.issue_valid); end
    n_vec++;
    cdb(4'd5, 32'h11);
    tick();
    idle();
    #1;
    if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL nomatch_half: got %b expected 0", bus.issue_valid); end
    n_vec++;
    cdb(4'd6, 32'h22);
    tick();
    idle();
    #1;
    if ({bus.issue_valid, bus.issue_vj, bus.issue_vk} !== {1'b1, 32'h11, 32'h22}) begin
      n_err++;
      $display("FAIL nomatch_values: got v=%b vj=%h vk=%h expected v=1 vj=11 vk=22", bus.issue_valid, bus.issue_vj, bus.issue_vk);
    end
    n_vec++;
    tick();
  endtask

  function automatic rs_ent_t snoop_model(input rs_ent_t e, input bit v, input logic [3:0] t, input logic [31:0] val);
    rs_ent_t r = e;
    if (v && r.jb && r.qj == t) begin r.vj = val; r.jb = 1'b0; end
    if (v && r.kb && r.qk == t) begin r.vk = val; r.kb = 1'b0; end
    return r;
  endfunction

  task automatic test_random();
    logic [112:0] exp_data, got_data;
    bit exp_rdy, exp_iv, fire_i, fire_d;
    int k;
    rs_ent_t ne;
    idle();
    bus.flush = 1'b1;
    tick();
    idle();
    model_q.delete();
    for (int c = 0; c < 400; c++) begin
      bus.flush         = ($urandom_range(0, 19) == 0);
      bus.disp_valid    = ($urandom_range(0, 9) < 6);
      bus.disp_unit     = 3'($urandom_range(0, 3));
      bus.disp_op       = 10'($urandom);
      bus.disp_pc_plus4 = $urandom;
      bus.disp_vj       = $urandom;
      bus.disp_vk       = $urandom;
      bus.disp_qj       = 4'($urandom_range(0, 3));
      bus.disp_qk       = 4'($urandom_range(0, 3));
      bus.disp_qj_busy  = 1'($urandom);
      bus.disp_qk_busy  = 1'($urandom);
      bus.disp_tag      = 4'($urandom);
      bus.cdb_valid     = 1'($urandom);
      bus.cdb_tag       = 4'($urandom_range(0, 5));
      bus.cdb_value     = $urandom;
      bus.issue_ready   = ($urandom_range(0, 9) < 7);
      #1;
      exp_rdy = model_q.size() < DEPTH;
      k = -1;
      for (int j = 0; j < model_q.size(); j++)
        if (k < 0 && !model_q[j].jb && !model_q[j].kb) k = j;
      exp_iv   = (k >= 0) && !bus.flush;
      exp_data = exp_iv ? {model_q[k].unit, model_q[k].op, model_q[k].pc, model_q[k].vj, model_q[k].vk, model_q[k].tag} : '0;
      got_data = {bus.issue_unit, bus.issue_op, bus.issue_pc_plus4, bus.issue_vj, bus.issue_vk, bus.issue_tag};
      if ({bus.disp_ready, bus.issue_valid} !== {exp_rdy, exp_iv}) begin
        n_err++;
        $display("FAIL rand_ctrl cycle %0d: got rdy=%b v=%b expected rdy=%b v=%b", c, bus.disp_ready, bus.issue_valid, exp_rdy, exp_iv);
      end
      n_vec++;
      if (got_data !== exp_data) begin
        n_err++;
        $display("FAIL rand_data cycle %0d: got %h expected %h", c, got_data, exp_data);
      end
      n_vec++;
      fire_i = exp_iv && bus.issue_ready;
      fire_d = bus.disp_valid && exp_rdy && !bus.flush;
      if (bus.flush) begin
        model_q.delete();
      end else begin
        if (fire_i) model_q.delete(k);
        for (int j = 0; j < model_q.size(); j++)
          model_q[j] = snoop_model(model_q[j], bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        if (fire_d) begin
          ne = '{unit: bus.disp_unit, op: bus.disp_op, pc: bus.disp_pc_plus4, vj: bus.disp_vj, vk: bus.disp_vk,
                 qj: bus.disp_qj, qk: bus.disp_qk, jb: bus.disp_qj_busy, kb: bus.disp_qk_busy, tag: bus.disp_tag};
          model_q.push_back(snoop_model(ne, bus.cdb_valid, bus.cdb_tag, bus.cdb_value));
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();
    bus.issue_ready = 1'b0;
    test_reset();
    test_wakeup();
    test_oldest_first();
    test_full_backpressure();
    test_flush();
    test_cdb_nomatch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reservation_station.md
# reservation_station

Operand-collecting issue queue that sits directly upstream of the execute stage and drives its `Unit`, `Op`, `pc_plus4`, `Vj` and `Vk` inputs. Decode/rename dispatches instructions with operands that are either values or pending tags. The station snoops the common data bus (CDB) to capture missing operands. It issues the oldest fully-ready entry to execute over a valid/ready handshake, and it empties completely on a pipeline flush.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; ≥2.
- `TAG_W`, 4: width of ROB/result tags.

Ports:
- `clk`  in  1  — the single clock.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `flush`  in  1  — discard all entries (branch taken / mispredict).
- `disp_valid`  in  1  — dispatch request.
- `disp_ready`  out  1  — station can accept a dispatch.
- `disp_unit`  in  3  — functional-unit code: ALU, BRANCH, MUL or DIV.
- `disp_op`  in  10  — operation code, passed through unchanged.
- `disp_pc_plus4`  in  32  — PC+4 of the instruction.
- `disp_vj`, `disp_vk`  in  32 each  — operand values; valid when the matching `q*_busy` is 0.
- `disp_qj`, `disp_qk`  in  TAG_W each  — producer tags.
- `disp_qj_busy`, `disp_qk_busy`  in  1 each  — operand still pending.
- `disp_tag`  in  TAG_W  — destination tag of this instruction.
- `cdb_valid`  in  1  — result broadcast this cycle.
- `cdb_tag`  in  TAG_W  — tag of the broadcast result.
- `cdb_value`  in  32  — value of the broadcast result.
- `issue_valid`  out  1  — an entry is presented to execute.
- `issue_ready`  in  1  — execute accepts it.
- `issue_unit`  out  3  — to execute.
- `issue_op`  out  10  — to execute.
- `issue_pc_plus4`  out  32  — to execute.
- `issue_vj`, `issue_vk`  out  32 each  — to execute.
- `issue_tag`  out  TAG_W  — destination tag that travels with the issued instruction.

## Operation
- Storage is a collapsing queue: slot 0 is the oldest entry, and valid slots are contiguous from 0. `count` ranges from 0 to DEPTH.
- Entry fields: valid, unit, op, pc_plus4, vj, vk, qj, qk, qj_busy, qk_busy, tag. An entry is ready when valid and both busy bits are 0.
- **Dispatch.** A dispatch fires when `disp_valid & disp_ready`. The entry is written to slot `count`, or to `count-1` when an issue fires in the same cycle.
- `disp_ready = (count < DEPTH)`, computed from registered state only. A slot freed by a same-cycle issue is not counted.
- **Wakeup.** For every valid entry with `q*_busy=1` and `q*==cdb_tag` while `cdb_valid`: at the clock edge, write `cdb_value` into `v*` and clear `q*_busy`. Both operands may wake on the same broadcast.
- **Dispatch bypass.** For a dispatching entry whose pending `q*` matches a valid CDB broadcast in the same cycle, capture `cdb_value` and store the operand as not busy.
- **Select.** Pick the lowest-index ready entry. `issue_valid` = that entry exists and `flush=0`. The `issue_*` outputs are combinational from the selected entry's registered fields. All `issue_*` data outputs are 0 when `issue_valid=0`.
- **Issue.** An issue fires when `issue_valid & issue_ready`. The selected slot is removed and every slot above it shifts down by one. CDB wakeup still applies to the shifted entries in the same edge.
- **Flush.** Takes priority over everything. At the edge, all valid bits and `count` clear, and the same-cycle dispatch is dropped. `issue_valid` is 0 while `flush=1`.
- **Reset.** All entries invalid, `count=0`, `disp_ready=1`, `issue_valid=0`, all `issue_*` data = 0.

## Timing
- Dispatch with both operands ready at edge t: `issue_valid=1` in cycle t+1. Minimum latency is 1; there is no combinational path from dispatch to issue.
- Operand woken by the CDB in cycle c: the entry is eligible in cycle c+1. Wakeup-to-issue bypass within a cycle is forbidden.
- Back-pressure: while `issue_ready=0`, the selected entry and all `issue_*` outputs hold stable, unless an older entry becomes ready. An older ready entry may preempt; execute has not yet accepted.
- Full with simultaneous issue: `disp_ready=0` still holds that cycle, and dispatch resumes the next cycle.
- Sustained throughput: one dispatch and one issue per cycle when `count < DEPTH`.
- Asserting `rst_n` low mid-operation clears state immediately, asynchronously. Entries in flight are lost.

## Test plan
- **Reset.** Hold `rst_n=0` with random inputs → `disp_ready=1`, `issue_valid=0`, `issue_vj=0`. Release, then dispatch ALU op 0x033 with vj=5, vk=7, tag=3, both not busy → next cycle `issue_valid=1`, `issue_vj=5`, `issue_vk=7`, `issue_tag=3`.
- **Wakeup and bypass.** Dispatch tag 1 with qj=9 busy → no issue. Drive CDB tag 9, value 0x1234 → the following cycle `issue_vj=0x1234`. Repeat with the CDB broadcast in the dispatch cycle itself → issue one cycle after dispatch with the captured value.
- **Oldest first.** Dispatch tags 1 (waiting on tag 8), 2 (ready), 3 (ready) → tag 2 issues, then 3. CDB tag 8 → tag 1 issues, and slots stay contiguous.
- **Full and back-pressure.** With `issue_ready=0`, fill DEPTH=4 → `disp_ready=0`, and the `issue_*` outputs stay stable for 5 cycles. Raise `issue_ready` for one cycle while dispatching → dispatch is refused that cycle and accepted the next, with `count` returning to 4.
- **Flush.** With 3 entries and a dispatch in the same cycle, pulse `flush` → `issue_valid=0` during the flush cycle; next cycle `count=0`, `disp_ready=1`, and no stale entry ever issues.
- **CDB on a non-matching tag or with `cdb_valid=0`** → no operand changes.
